duty_feeder: RTL and testbench

DUTY_FEEDER -- requirements
Module: duty_feeder

---
 rtl/duty_feeder.sv | 111 +++++++++++
 tb/tb_duty_feeder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/duty_feeder.sv
// Sample FIFO that reloads a PWM duty register once per PWM period, in lockstep with the PWM counter.
// Define DUTY_FEEDER_HOLD_EN to hold the last duty on underflow instead of falling back to midscale.
module duty_feeder #(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     step,
  input  logic [N-1:0]             s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [N-1:0]             duty,
  output logic                     period_start,
  output logic                     underflow,
  output logic [7:0]               underflow_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [N-1:0]  MIDSCALE   = N'(1) << (N - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [7:0]    UF_MAX     = 8'hFF;

  logic [N-1:0]  cnt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [N-1:0]  mem [DEPTH];

  logic          advance_c;
  logic          boundary_c;
  logic          push_c;
  logic          pop_c;
  logic          empty_pop_c;
  logic [N-1:0]  uf_value_c;

  // Boundary is the edge on which the period counter wraps, same as the PWM counter.
  assign advance_c   = ena & step;
  assign boundary_c  = advance_c & (cnt == '1);
  assign s_ready     = (level < FULL_LEVEL);
  assign push_c      = s_valid & s_ready;
  assign pop_c       = boundary_c & (level != '0);
  assign empty_pop_c = boundary_c & (level == '0);

`ifdef DUTY_FEEDER_HOLD_EN
  assign uf_value_c = duty;
`else
  assign uf_value_c = MIDSCALE;
`endif

  // Period counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (advance_c) begin
      cnt <= cnt + N'(1);
    end
  end

  // FIFO pointers and occupancy; a pop of an empty FIFO leaves them alone
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_c, pop_c})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Sample storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // Duty reload and status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty            <= MIDSCALE;
      period_start    <= 1'b0;
      underflow       <= 1'b0;
      underflow_count <= '0;
    end else begin
      period_start <= boundary_c;
      underflow    <= empty_pop_c;
      if (pop_c) begin
        duty <= mem[rd_ptr];
      end else if (empty_pop_c) begin
        duty <= uf_value_c;
      end
      if (empty_pop_c && (underflow_count != UF_MAX)) begin
        underflow_count <= underflow_count + 8'(1);
      end
    end
  end

endmodule

// File: tb/tb_duty_feeder.sv
// Self-checking bench for duty_feeder: vector table, directed corner sequences and a random run
// compared every cycle against a queue-based model of the duty feeder.
module tb_duty_feeder;

`ifdef DUTY_FEEDER_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       ena;
  logic       step;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] duty;
  logic       period_start;
  logic       underflow;
  logic [7:0] underflow_count;
  logic [4:0] level;

  duty_feeder #(.N(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .ena(ena), .step(step),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .duty(duty), .period_start(period_start), .underflow(underflow),
    .underflow_count(underflow_count), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int         m_cnt;
  logic [7:0] q[$];
  logic [7:0] m_duty;
  bit         m_ps;
  bit         m_uf;
  int         m_ufc;

  typedef struct {
    logic       ena;
    logic       step;
    logic       s_valid;
    logic [7:0] s_data;
    int         exp_level;
    logic       exp_ready;
    logic [7:0] exp_duty;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d (0x%0h), want %0d (0x%0h)", name, $time, act, act, exp, exp);
    end
  endtask

  function automatic void model_reset();
    m_cnt  = 0;
    q.delete();
    m_duty = 8'h80;
    m_ps   = 1'b0;
    m_uf   = 1'b0;
    m_ufc  = 0;
  endfunction

  // One clock edge of the feeder, written from the period / queue rules
  function automatic void model_step(bit en, bit st, bit sv, logic [7:0] sd);
    bit bnd;
    bit rdy;
    bnd  = en && st && (m_cnt == 255);
    rdy  = (q.size() < 16);
    m_ps = bnd;
    m_uf = 1'b0;
    if (en && st) m_cnt = (m_cnt + 1) % 256;
    if (bnd) begin
      if (q.size() > 0) begin
        m_duty = q.pop_front();
      end else begin
        m_uf = 1'b1;
        if (!HOLD) m_duty = 8'h80;
        if (m_ufc < 255) m_ufc++;
      end
    end
    if (sv && rdy) q.push_back(sd);
  endfunction

  task automatic check_all();
    chk("duty", int'(duty), int'(m_duty));
    chk("level", int'(level), q.size());
    chk("s_ready", int'(s_ready), int'(q.size() < 16));
    chk("period_start", int'(period_start), int'(m_ps));
    chk("underflow", int'(underflow), int'(m_uf));
    chk("underflow_count", int'(underflow_count), m_ufc);
  endtask

  task automatic tick();
    model_step(ena, step, s_valid, s_data);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst     = 1'b1;
    ena     = 1'b0;
    step    = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
  endtask

  task automatic run_to_boundary(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!period_start && n < limit);
    chk("boundary_seen", int'(period_start), 1);
  endtask

  initial begin
    int n;
    int total;

    for (int i = 0; i < 17; i++) begin
      vecs[i].ena       = 1'b1;
      vecs[i].step      = 1'b0;
      vecs[i].s_valid   = 1'b1;
      vecs[i].s_data    = 8'(i + 1);
      vecs[i].exp_level = (i + 1 > 16) ? 16 : i + 1;
      vecs[i].exp_ready = (i + 1 < 16);
      vecs[i].exp_duty  = 8'h80;
    end

    // Reset with inputs toggling randomly
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      ena     = 1'($urandom);
      step    = 1'($urandom);
      s_valid = 1'($urandom);
      s_data  = 8'($urandom);
      @(posedge clk);
      #1;
      chk("rst_duty", int'(duty), 'h80);
      chk("rst_level", int'(level), 0);
      chk("rst_ready", int'(s_ready), 1);
      chk("rst_ufc", int'(underflow_count), 0);
    end
    rst = 1'b1;
    ena = 1'b0; step = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    @(posedge clk);
    #1;

    // Fill to full with no steps; the 17th sample is held off
    do_reset();
    for (int i = 0; i < 17; i++) begin
      ena = vecs[i].ena; step = vecs[i].step;
      s_valid = vecs[i].s_valid; s_data = vecs[i].s_data;
      tick();
      chk("tbl_level", int'(level), vecs[i].exp_level);
      chk("tbl_ready", int'(s_ready), int'(vecs[i].exp_ready));
      chk("tbl_duty", int'(duty), int'(vecs[i].exp_duty));
    end
    step = 1'b1;
    run_to_boundary(300, n);
    chk("full_bnd_steps", n, 256);
    chk("full_bnd_duty", int'(duty), 1);
    chk("full_bnd_level", int'(level), 15);
    tick();
    chk("full_17th_level", int'(level), 16);
    s_valid = 1'b0;

    // Ordering through two periods, then an underflow
    do_reset();
    ena = 1'b1; step = 1'b1; s_valid = 1'b1; s_data = 8'h10;
    tick();
    s_data = 8'h20;
    tick();
    s_valid = 1'b0;
    n = 2;
    while (!period_start && n < 300) begin tick(); n++; end
    chk("ord_first_steps", n, 256);
    chk("ord_first_duty", int'(duty), 'h10);
    tick();
    chk("ord_ps_one_cycle", int'(period_start), 0);
    run_to_boundary(300, n);
    chk("ord_second_steps", n + 1, 256);
    chk("ord_second_duty", int'(duty), 'h20);

    // Underflow from a known duty, then saturation of the counter
    do_reset();
    ena = 1'b1; step = 1'b1; s_valid = 1'b1; s_data = 8'h33;
    tick();
    s_valid = 1'b0;
    run_to_boundary(300, n);
    chk("uf_pre_duty", int'(duty), 'h33);
    run_to_boundary(300, n);
    chk("uf_pulse", int'(underflow), 1);
    chk("uf_count_one", int'(underflow_count), 1);
    chk("uf_duty", int'(duty), HOLD ? 'h33 : 'h80);

    // Stall at counter 100 for 50 cycles
    do_reset();
    ena = 1'b1; step = 1'b1; s_valid = 1'b1; s_data = 8'h44;
    tick();
    s_valid = 1'b0;
    for (int i = 1; i < 100; i++) tick();
    ena = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    chk("stall_no_pop", int'(level), 1);
    ena = 1'b1;
    run_to_boundary(400, n);
    total = 150 + n;
    chk("stall_bnd_cycles", total, 306);
    chk("stall_duty", int'(duty), 'h44);

    // Reset mid-stream discards the queue
    do_reset();
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = 8'(8'hA0 + i);
      tick();
    end
    s_valid = 1'b0;
    chk("mid_level_before", int'(level), 5);
    rst = 1'b0;
    model_reset();
    #1;
    chk("mid_level_async", int'(level), 0);
    chk("mid_duty_async", int'(duty), 'h80);
    @(posedge clk);
    #1;
    rst = 1'b1;
    ena = 1'b1; step = 1'b1;
    run_to_boundary(300, n);
    chk("mid_first_bnd_steps", n, 256);
    chk("mid_underflow", int'(underflow), 1);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (!(s_valid && !s_ready)) begin
        s_valid = ($urandom_range(0, 999) < ((i < 2000) ? 20 : 2));
        s_data  = 8'($urandom);
      end
      ena  = ($urandom_range(0, 9) != 0);
      step = ($urandom_range(0, 7) != 0);
      tick();
    end

    // Drive past 255 underflows
    do_reset();
    ena = 1'b1; step = 1'b1; s_valid = 1'b0;
    for (int i = 0; i < 258; i++) run_to_boundary(300, n);
    chk("uf_saturate", int'(underflow_count), 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
